// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, FSM state type and address helpers for mem_responder
package mem_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic {LOAD, RUN} state_t;
    function automatic logic [31:0] word_idx(input logic [31:0] addr);
        return addr >> 2;
    endfunction
    function automatic logic in_range(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> (addr_w + 2)) == 32'd0;
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: core IMEM/DMEM pins plus boot-loader stream and status
interface mem_responder_if;
    logic [31:0] IMEM_addr_i;
    logic        IMEM_read_n_i;
    logic [31:0] IMEM_data_o;
    logic [31:0] DMEM_addr_i;
    logic        DMEM_read_i;
    logic        DMEM_write_i;
    logic [31:0] DMEM_data_i;
    logic [31:0] DMEM_data_o;
    logic        load_valid_i;
    logic [31:0] load_data_i;
    logic        load_last_i;
    logic        load_ready_o;
    logic        core_reset_n_o;
    logic        err_o;
    modport slave (
        input  IMEM_addr_i, IMEM_read_n_i, DMEM_addr_i, DMEM_read_i, DMEM_write_i, DMEM_data_i,
               load_valid_i, load_data_i, load_last_i,
        output IMEM_data_o, DMEM_data_o, load_ready_o, core_reset_n_o, err_o
    );
    modport master (
        output IMEM_addr_i, IMEM_read_n_i, DMEM_addr_i, DMEM_read_i, DMEM_write_i, DMEM_data_i,
               load_valid_i, load_data_i, load_last_i,
        input  IMEM_data_o, DMEM_data_o, load_ready_o, core_reset_n_o, err_o
    );
endinterface

// File: rtl/mem_word_ram.sv
// mem_word_ram: word array with a read/write port A and a read-only port B, read-before-write
module mem_word_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              a_re,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [31:0]       a_wdata,
    output logic [31:0]       a_rdata,
    input  logic              b_re,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [31:0]       b_rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    // Port A: write and read share the address; read data holds when not enabled
    always_ff @(posedge clk) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (a_re) a_rdata <= mem[a_addr];
    end
    // Port B: fetch read sees the pre-write contents of a same-cycle port A write
    always_ff @(posedge clk) begin
        if (b_re) b_rdata <= mem[b_addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: boot-loads a shared word array, then serves core fetch and data accesses
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_responder_if.slave  bus
);
    state_t            state, state_nx;
    logic [ADDR_W-1:0] load_ptr, i_idx, d_idx, a_addr;
    logic [31:0]       a_wdata, i_rdata, d_rdata;
    logic              run, beat, i_ok, d_ok, i_rd, d_rd, d_wr, a_we, a_re, b_re;
    logic              i_ram, d_ram, core_run, err;

    assign i_idx = ADDR_W'(word_idx(bus.IMEM_addr_i));
    assign d_idx = ADDR_W'(word_idx(bus.DMEM_addr_i));
    assign i_ok  = in_range(bus.IMEM_addr_i, ADDR_W);
    assign d_ok  = in_range(bus.DMEM_addr_i, ADDR_W);

    // Loader FSM plus request qualification; core requests only count in RUN
    always_comb begin
        state_nx = state;
        run      = state == RUN;
        beat     = bus.load_valid_i && !run;
        if (beat && (bus.load_last_i || load_ptr == ADDR_W'(DEPTH_WORDS - 1))) state_nx = RUN;
        i_rd    = run && !bus.IMEM_read_n_i;
        d_rd    = run && bus.DMEM_read_i && !bus.DMEM_write_i;
        d_wr    = run && bus.DMEM_write_i;
        b_re    = i_rd && i_ok;
        a_re    = d_rd && d_ok;
        a_we    = run ? d_wr && d_ok : beat;
        a_addr  = run ? d_idx : load_ptr;
        a_wdata = run ? bus.DMEM_data_i : bus.load_data_i;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_nx;
    end

    // Load pointer, delayed core release, sticky error and per-port "RAM data valid" flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_ptr <= '0;
            core_run <= 1'b0;
            err      <= 1'b0;
            i_ram    <= 1'b0;
            d_ram    <= 1'b0;
        end else begin
            if (beat) load_ptr <= load_ptr + 1'b1;
            core_run <= run;
            if ((i_rd && !i_ok) || ((d_rd || d_wr) && !d_ok)) err <= 1'b1;
            if (i_rd) i_ram <= i_ok;
            if (d_rd) d_ram <= d_ok;
        end
    end

    mem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .a_re    (a_re),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_rdata (d_rdata),
        .b_re    (b_re),
        .b_addr  (i_idx),
        .b_rdata (i_rdata)
    );

    // RAM read registers hold while a port is idle, so the flags select hold, NOP or zero
    assign bus.IMEM_data_o    = i_ram ? i_rdata : NOP_INSTR;
    assign bus.DMEM_data_o    = d_ram ? d_rdata : 32'd0;
    assign bus.load_ready_o   = !run;
    assign bus.core_reset_n_o = core_run;
    assign bus.err_o          = err;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus randomized checks of mem_responder against a word-array model
module tb_mem_responder;
    localparam int D = 64;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [31:0] model [D];
    logic [31:0] exp_i, exp_d, wd;
    logic [2:0] ia, da;
    logic ir, dr, dw;

    mem_responder_if bus ();
    mem_responder #(.DEPTH_WORDS(D)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk32({tag, "_imem"}, bus.IMEM_data_o, 32'h0000_0013);
        chk32({tag, "_dmem"}, bus.DMEM_data_o, 32'd0);
        chk1({tag, "_ready"}, bus.load_ready_o, 1'b1);
        chk1({tag, "_core_rst"}, bus.core_reset_n_o, 1'b0);
        chk1({tag, "_err"}, bus.err_o, 1'b0);
    endtask

    task automatic beat(input logic [31:0] data, input logic last);
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = data;
        bus.load_last_i  = last;
        tick();
        bus.load_valid_i = 1'b0;
        bus.load_last_i  = 1'b0;
    endtask

    task automatic imem_read(input logic [31:0] addr);
        bus.IMEM_addr_i   = addr;
        bus.IMEM_read_n_i = 1'b0;
        tick();
        bus.IMEM_read_n_i = 1'b1;
    endtask

    task automatic dmem_write(input logic [31:0] addr, input logic [31:0] data);
        bus.DMEM_addr_i  = addr;
        bus.DMEM_data_i  = data;
        bus.DMEM_write_i = 1'b1;
        tick();
        bus.DMEM_write_i = 1'b0;
    endtask

    initial begin
        bus.IMEM_addr_i   = '0;
        bus.IMEM_read_n_i = 1'b1;
        bus.DMEM_addr_i   = '0;
        bus.DMEM_read_i   = 1'b0;
        bus.DMEM_write_i  = 1'b0;
        bus.DMEM_data_i   = '0;
        bus.load_valid_i  = 1'b0;
        bus.load_data_i   = '0;
        bus.load_last_i   = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        reset_n = 1'b1;

        // boot load of 4 beats while the core pins try (and fail) to access memory
        bus.IMEM_read_n_i = 1'b0;
        bus.IMEM_addr_i   = 32'h8000_0000;
        bus.DMEM_write_i  = 1'b1;
        bus.DMEM_addr_i   = 32'h0;
        bus.DMEM_data_i   = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            beat(32'hA0 + 32'(i), i == 3);
            model[i] = 32'hA0 + 32'(i);
            chk1("load_ready", bus.load_ready_o, i < 3);
        end
        bus.IMEM_read_n_i = 1'b1;
        bus.DMEM_write_i  = 1'b0;
        chk1("core_rst_after_last", bus.core_reset_n_o, 1'b0);
        chk1("err_load_ignored", bus.err_o, 1'b0);
        chk32("imem_load_ignored", bus.IMEM_data_o, 32'h0000_0013);
        tick();
        chk1("core_rst_released", bus.core_reset_n_o, 1'b1);
        for (int i = 0; i < 4; i++) begin
            imem_read(32'(4 * i));
            chk32("imem_boot_word", bus.IMEM_data_o, model[i]);
        end

        // fetch hold while the address moves
        imem_read(32'h4);
        bus.IMEM_addr_i = 32'h8;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk32("imem_hold", bus.IMEM_data_o, 32'hA1);
        end

        // store then load, with fetch of the same word in the store cycle
        dmem_write(32'h10, 32'h1111_2222);
        model[4] = 32'h1111_2222;
        bus.DMEM_addr_i   = 32'h10;
        bus.DMEM_data_i   = 32'hDEAD_BEEF;
        bus.DMEM_write_i  = 1'b1;
        bus.DMEM_read_i   = 1'b1;
        bus.IMEM_addr_i   = 32'h10;
        bus.IMEM_read_n_i = 1'b0;
        tick();
        bus.IMEM_read_n_i = 1'b1;
        bus.DMEM_write_i  = 1'b0;
        chk32("imem_read_before_write", bus.IMEM_data_o, 32'h1111_2222);
        chk32("dmem_write_wins_hold", bus.DMEM_data_o, 32'd0);
        model[4] = 32'hDEAD_BEEF;
        bus.DMEM_addr_i = 32'h12;
        tick();
        bus.DMEM_read_i = 1'b0;
        chk32("dmem_readback", bus.DMEM_data_o, 32'hDEAD_BEEF);

        // randomized traffic on words 0..7 against the array model
        exp_i = 32'h1111_2222;
        exp_d = 32'hDEAD_BEEF;
        for (int w = 0; w < 8; w++) begin
            wd = $urandom;
            dmem_write(32'(4 * w), wd);
            model[w] = wd;
        end
        for (int n = 0; n < 200; n++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            ia = 3'($urandom_range(0, 7));
            da = 3'($urandom_range(0, 7));
            wd = $urandom;
            bus.IMEM_addr_i   = {27'd0, ia, 2'($urandom_range(0, 3))};
            bus.IMEM_read_n_i = !ir;
            bus.DMEM_addr_i   = {27'd0, da, 2'($urandom_range(0, 3))};
            bus.DMEM_read_i   = dr;
            bus.DMEM_write_i  = dw;
            bus.DMEM_data_i   = wd;
            tick();
            if (ir) exp_i = model[ia];
            if (dr && !dw) exp_d = model[da];
            if (dw) model[da] = wd;
            chk32("rand_imem", bus.IMEM_data_o, exp_i);
            chk32("rand_dmem", bus.DMEM_data_o, exp_d);
        end
        bus.IMEM_read_n_i = 1'b1;
        bus.DMEM_read_i   = 1'b0;
        bus.DMEM_write_i  = 1'b0;
        chk1("err_in_range", bus.err_o, 1'b0);

        // out-of-range accesses
        bus.DMEM_addr_i = 32'(4 * D);
        bus.DMEM_read_i = 1'b1;
        tick();
        bus.DMEM_read_i = 1'b0;
        chk32("dmem_oor_zero", bus.DMEM_data_o, 32'd0);
        chk1("err_set", bus.err_o, 1'b1);
        imem_read(32'(4 * D));
        chk32("imem_oor_nop", bus.IMEM_data_o, 32'h0000_0013);
        dmem_write(32'(4 * D), 32'hFFFF_FFFF);
        imem_read(32'h0);
        chk32("oor_write_dropped", bus.IMEM_data_o, model[0]);
        tick();
        chk1("err_sticky", bus.err_o, 1'b1);

        // reset from RUN, then full-depth load with no last flag
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < D; i++) begin
            wd = $urandom;
            beat(wd, 1'b0);
            model[i] = wd;
            if (i == D - 2) chk1("full_ready_before_last", bus.load_ready_o, 1'b1);
        end
        chk1("full_ready_dropped", bus.load_ready_o, 1'b0);
        beat(32'hEEEE_EEEE, 1'b0);
        chk1("full_extra_ignored_ready", bus.load_ready_o, 1'b0);
        chk1("full_core_rst", bus.core_reset_n_o, 1'b1);
        for (int i = 0; i < D; i++) begin
            imem_read(32'(4 * i));
            chk32("full_word", bus.IMEM_data_o, model[i]);
        end

        // reset in the middle of a load; array contents survive
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        beat(32'h77, 1'b0);
        beat(32'h88, 1'b0);
        model[0] = 32'h77;
        model[1] = 32'h88;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("midload_rst");
        tick();
        reset_n = 1'b1;
        beat(32'h55, 1'b1);
        model[0] = 32'h55;
        chk1("reload_ready", bus.load_ready_o, 1'b0);
        tick();
        chk1("reload_core_rst", bus.core_reset_n_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            imem_read(32'(4 * i));
            chk32("reload_word", bus.IMEM_data_o, model[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
